// File: rtl/controlador_sequencia_rpn.sv
// Sequencer for the RPN calculator datapath: turns push events into one-cycle
// load enables for A, B and OP, waits for the ULA, then captures the result.
module controlador_sequencia_rpn #(
    parameter int SYNC_STAGES  = 2,
    parameter int LATENCIA_ULA = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push_pilha,
    input  logic       limpar,
    input  logic [7:0] entrada_numero,
    input  logic       erro_ula,
    output logic       en_reg_a,
    output logic       en_reg_b,
    output logic       en_reg_op,
    output logic       en_resultado,
    output logic [2:0] estado,
    output logic       entrada_numero_a,
    output logic       entrada_numero_b,
    output logic       entrada_operacao,
    output logic       resultado_valido,
    output logic       erro_latch,
    output logic       op_invalida,
    output logic       ocupado
);

    typedef enum logic [2:0] {
        S_A    = 3'd0,
        S_B    = 3'd1,
        S_OP   = 3'd2,
        S_EXEC = 3'd3,
        S_RES  = 3'd4
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;
    logic                   evt;
    logic                   op_ok;
    logic [3:0]             cnt;
    logic                   unused_bits;

    // Flops reset to 1 so a button held through reset release yields no event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= '1;
            prev <= 1'b1;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], push_pilha};
            prev <= sync[SYNC_STAGES-1];
        end
    end

    assign evt         = sync[SYNC_STAGES-1] & ~prev;
    assign op_ok       = (entrada_numero[7:3] == 5'd0);
    assign unused_bits = ^entrada_numero[2:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_A;
            en_reg_a     <= 1'b0;
            en_reg_b     <= 1'b0;
            en_reg_op    <= 1'b0;
            en_resultado <= 1'b0;
            erro_latch   <= 1'b0;
            op_invalida  <= 1'b0;
            cnt          <= '0;
        end else begin
            en_reg_a     <= 1'b0;
            en_reg_b     <= 1'b0;
            en_reg_op    <= 1'b0;
            en_resultado <= 1'b0;
            if (limpar) begin
                state       <= S_A;
                erro_latch  <= 1'b0;
                op_invalida <= 1'b0;
                cnt         <= '0;
            end else begin
                case (state)
                    S_B: begin
                        if (evt) begin
                            en_reg_b <= 1'b1;
                            state    <= S_OP;
                        end
                    end
                    S_OP: begin
                        if (evt) begin
                            if (op_ok) begin
                                en_reg_op   <= 1'b1;
                                op_invalida <= 1'b0;
                                cnt         <= 4'(LATENCIA_ULA);
                                state       <= S_EXEC;
                            end else begin
                                op_invalida <= 1'b1;
                            end
                        end
                    end
                    S_EXEC: begin
                        if (cnt == 4'd0) begin
                            en_resultado <= 1'b1;
                            erro_latch   <= erro_ula;
                            state        <= S_RES;
                        end else begin
                            cnt <= cnt - 4'd1;
                        end
                    end
                    S_RES: begin
                        if (evt) begin
                            en_reg_a   <= 1'b1;
                            erro_latch <= 1'b0;
                            state      <= S_B;
                        end
                    end
                    // S_A and the unreachable codes behave identically
                    default: begin
                        if (evt) begin
                            en_reg_a <= 1'b1;
                            state    <= S_B;
                        end else begin
                            state <= S_A;
                        end
                    end
                endcase
            end
        end
    end

    assign estado           = state;
    assign entrada_numero_a = (state == S_A);
    assign entrada_numero_b = (state == S_B);
    assign entrada_operacao = (state == S_OP);
    assign resultado_valido = (state == S_RES);
    assign ocupado          = (state == S_EXEC);

endmodule
